// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit with a start/busy/done
// handshake. Magnitudes are iterated unsigned; signs are applied in FIX.
//
//   state | meaning
//   IDLE  | waiting for iStart
//   MUL   | shift-add on magnitudes, one multiplier bit per cycle
//   DIV   | restoring division on magnitudes, one quotient bit per cycle
//   FIX   | apply signs, select the word, register oResult
//   DONE  | oDone pulse; may accept a new iStart
//
// Divide-by-zero and signed overflow skip the iteration. They still pass
// through FIX for one cycle, so that oBusy is high for exactly one cycle and
// oDone follows one edge later.
module muldiv_iter (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iStart,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic [31:0] oResult,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic        sign_a, sign_b, fast;
  logic [31:0] mag;        // multiplicand for MUL, divisor for DIV
  logic [63:0] acc;        // {hi, multiplier} or {remainder, quotient}
  logic [5:0]  cnt;
  logic [31:0] result;

  // Decode of the incoming request.
  logic        is_div, a_signed, b_signed, div_zero, div_ovf, accept;
  logic [31:0] abs_a, abs_b, fast_val;

  assign is_div   = iFunct3[2];
  assign a_signed = is_div ? ~iFunct3[0] : (iFunct3 != 3'b011);
  assign b_signed = is_div ? ~iFunct3[0] : ~iFunct3[1];
  assign abs_a    = (a_signed && iA[31]) ? (32'd0 - iA) : iA;
  assign abs_b    = (b_signed && iB[31]) ? (32'd0 - iB) : iB;
  assign div_zero = is_div && (iB == 32'd0);
  assign div_ovf  = is_div && !iFunct3[0] && (iA == 32'h8000_0000) && (iB == 32'hFFFF_FFFF);
  assign fast_val = div_zero ? (iFunct3[1] ? iA : 32'hFFFF_FFFF)
                             : (iFunct3[1] ? 32'd0 : 32'h8000_0000);
  assign accept   = iStart && (state == S_IDLE || state == S_DONE);

  // One iteration of each algorithm.
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] mul_step, div_step;

  assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
  assign mul_step  = {mul_sum, acc[31:1]};
  assign div_shift = {acc[63:32], acc[31]};
  assign div_diff  = div_shift - {1'b0, mag};
  assign div_step  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                  : {div_diff[31:0], acc[30:0], 1'b1};

  // Sign fix-up and word selection.
  logic [63:0] prod;
  logic [31:0] quo, rem, fix_val;

  assign prod = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
  assign quo  = (sign_a ^ sign_b) ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem  = sign_a ? (32'd0 - acc[63:32]) : acc[63:32];

  // Result word for the operation held in op.
  always_comb begin
    fix_val = acc[31:0];
    if (!fast) begin
      case (op)
        3'b000:                 fix_val = prod[31:0];
        3'b001, 3'b010, 3'b011: fix_val = prod[63:32];
        3'b100, 3'b101:         fix_val = quo;
        default:                fix_val = rem;
      endcase
    end
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    oBusy     = 1'b0;
    oDone     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        oDone = (state == S_DONE);
        if (iStart) begin
          if (div_zero || div_ovf) state_nxt = S_FIX;
          else if (is_div)         state_nxt = S_DIV;
          else                     state_nxt = S_MUL;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        oBusy = 1'b1;
        if (cnt == 6'd0) state_nxt = S_FIX;
      end
      S_FIX: begin
        oBusy     = 1'b1;
        state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      op     <= 3'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      fast   <= 1'b0;
      mag    <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 6'd0;
      result <= 32'd0;
    end else begin
      if (accept) begin
        op     <= iFunct3;
        sign_a <= a_signed && iA[31];
        sign_b <= b_signed && iB[31];
        fast   <= div_zero || div_ovf;
        cnt    <= 6'd32;
        if (div_zero || div_ovf) begin
          acc <= {32'd0, fast_val};
          mag <= 32'd0;
        end else if (is_div) begin
          acc <= {32'd0, abs_a};
          mag <= abs_b;
        end else begin
          acc <= {32'd0, abs_b};
          mag <= abs_a;
        end
      end else if (state == S_MUL && cnt != 6'd0) begin
        acc <= mul_step;
        cnt <= cnt - 6'd1;
      end else if (state == S_DIV && cnt != 6'd0) begin
        acc <= div_step;
        cnt <= cnt - 6'd1;
      end
      if (state == S_FIX) result <= fix_val;
    end
  end

  assign oResult = result;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: directed vectors for muldiv_iter with hand-computed results.
module tb_muldiv_iter;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iStart;
  logic [2:0]  iFunct3;
  logic [31:0] iA, iB;
  logic [31:0] oResult;
  logic        oBusy, oDone;

  int n_chk = 0;
  int n_bad = 0;

  muldiv_iter dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .iFunct3(iFunct3),
    .iA(iA), .iB(iB), .oResult(oResult), .oBusy(oBusy), .oDone(oDone)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request now, let the next edge accept it, then scramble inputs.
  task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    iStart = 1'b1; iFunct3 = f3; iA = a; iB = b;
    @(posedge iCLK); #1;
    iStart = 1'b0; iFunct3 = ~f3; iA = $urandom; iB = $urandom;
  endtask

  // Count edges until oDone, checking latency, result and busy coverage.
  task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_lat, input int lat0);
    int lat = lat0;
    bit busy_ok = 1'b1;
    while (!oDone && lat < 60) begin
      if (!oBusy) busy_ok = 1'b0;
      @(posedge iCLK); #1;
      lat++;
    end
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " res"}, oResult, exp);
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy_in_done"}, {31'd0, oBusy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    @(negedge iCLK);
    launch(f3, a, b);
    wait_done(tag, exp, exp_lat, 0);
  endtask

  initial begin
    bit saw_done;
    iRST_N = 1'b0; iStart = 1'b0; iFunct3 = 3'd0; iA = 32'd0; iB = 32'd0;
    #12;
    check("rst result", oResult, 32'd0);
    check("rst busy", {31'd0, oBusy}, 32'd0);
    check("rst done", {31'd0, oDone}, 32'd0);
    @(negedge iCLK); iRST_N = 1'b1;

    run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    @(posedge iCLK); #1;
    check("hold", oResult, 32'hFFFF_FFEB);
    run_op("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34);
    run_op("divneg", 3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    run_op("remneg", 3'b110, 32'd7,          32'hFFFF_FFFE, 32'd1,         34);
    run_op("divu",   3'b101, 32'd100,        32'd7,         32'd14,        34);
    run_op("remu",   3'b111, 32'd100,        32'd7,         32'd2,         34);
    run_op("divu0",  3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
    run_op("rem0",   3'b110, 32'd5,          32'd0,         32'd5,         1);
    run_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

    // Start pulse while busy must be ignored.
    @(negedge iCLK);
    launch(3'b000, 32'd7, 32'hFFFF_FFFD);
    repeat (9) begin @(posedge iCLK); #1; end
    iStart = 1'b1; iFunct3 = 3'b011; iA = 32'd2; iB = 32'd3;
    @(posedge iCLK); #1;
    iStart = 1'b0;
    wait_done("ignore", 32'hFFFF_FFEB, 34, 10);

    // Back-to-back: new start accepted during DONE.
    launch(3'b101, 32'd100, 32'd7);
    check("b2b busy", {31'd0, oBusy}, 32'd1);
    check("b2b done", {31'd0, oDone}, 32'd0);
    wait_done("b2b", 32'd14, 34, 0);

    // Reset in the middle of a divide.
    @(negedge iCLK);
    launch(3'b100, 32'hFFFF_FFF9, 32'd2);
    repeat (15) begin @(posedge iCLK); #1; end
    iRST_N = 1'b0;
    #1;
    check("midrst result", oResult, 32'd0);
    check("midrst busy", {31'd0, oBusy}, 32'd0);
    check("midrst done", {31'd0, oDone}, 32'd0);
    @(negedge iCLK); @(negedge iCLK);
    iRST_N = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge iCLK); #1;
      if (oDone) saw_done = 1'b1;
    end
    check("midrst no_done", {31'd0, saw_done}, 32'd0);
    run_op("after_rst", 3'b000, 32'd6, 32'd9, 32'd54, 34);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
